load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage placed directly downstream of the execute-stage ALU. It takes the ALU result as a byte address, plus the rs2 store data and funct3, and performs RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a word-addressed data memory that has no byte enables. Sub-word stores are done as a read-modify-write sequence. Load data is returned sign- or zero-extended to the writeback stage.

## Interface
- DMEM_AW, 30, width of the word address to data memory; equals the byte address bits [DMEM_AW+1:2].
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from EX stage.
- req_ready  out  1  high only in IDLE; request accepted on a cycle with req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access finished.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned access or illegal funct3.
- dmem_addr  out  DMEM_AW  word address.
- dmem_ren  out  1  read strobe.
- dmem_wen  out  1  write strobe; never high together with dmem_ren.
- dmem_wdata  out  32  full write word.
- dmem_rdata  in  32  read word; valid in any cycle with dmem_ren=1 and dmem_stall=0.
- dmem_stall  in  1  memory busy; the access completes in the first cycle in which the strobe is high and dmem_stall=0.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR.
- On acceptance, register req_addr, req_wdata, req_funct3 and req_we.
  - Inputs may change after acceptance.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misaligned accesses:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
- Illegal or misaligned request:
  - No memory access; the state stays IDLE.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
- State transitions for legal requests:
  - Load: IDLE→RD. RD holds while dmem_stall=1, then →IDLE on completion.
  - SW: IDLE→WR. WR holds while stalled, then →IDLE.
  - SB/SH: IDLE→RMW_RD. RMW_RD holds while stalled. On completion, capture the merged word, then →RMW_WR. RMW_WR holds while stalled, then →IDLE.
- Strobes per state:
  - dmem_ren=1 in RD and RMW_RD only.
  - dmem_wen=1 in WR and RMW_WR only.
- Strobe stability:
  - dmem_addr = captured addr[DMEM_AW+1:2], constant from the state's first cycle until it completes.
  - dmem_wdata stays constant for the same span.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0].
  - Halfword uses lane addr[1]*16.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Store merge:
  - SB replaces byte k of the read word with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - SW writes wdata unchanged.
- resp_rdata and resp_err are registered and change only when resp_valid is asserted. They hold their value otherwise.
- Asynchronous reset:
  - rst_n low forces state IDLE and all registers to 0 immediately, including mid-access.
  - A pending access is dropped with no response.
  - A partially done RMW does not write.

## Timing
- Reset values:
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - dmem_ren=0, dmem_wen=0, dmem_addr=0, dmem_wdata=0.
- Request accepted at cycle T:
  - Strobe is first high at T+1.
  - With no stall, a load or SW completes at T+1 and resp_valid is high at T+2.
  - With no stall, an SB/SH reads at T+1, writes at T+2, and resp_valid is high at T+3.
- Each stall cycle adds one cycle of latency to the access it occurs in.
- Error response comes at T+1.
- Back-to-back requests:
  - req_ready returns high in the same cycle as resp_valid.
  - A new request may be accepted in that cycle.
- req_ready is combinational from state.
- All other outputs are registered or decoded from registered state. There is no combinational path from dmem_rdata or dmem_stall to any output.

## Test plan
- Reset mid-access: assert rst_n=0 in RD while dmem_stall=1 → same cycle ren=0, req_ready=1, resp_valid=0. After release there is no spurious resp_valid.
- LW 0x00000104 with stall=0 and rdata=0xDEADBEEF → dmem_addr=0x41 and ren=1 at T+1. resp_valid=1, rdata=0xDEADBEEF, err=0 at T+2.
- LB / LBU 0x103 with rdata=0x80FF0000 → 0xFFFFFF80 / 0x00000080. LH 0x102 → 0xFFFF80FF.
- SB 0x102, wdata=0x000000AB, memory word 0x11223344 → ren at T+1, then wen at T+2 with wdata=0x11AB3344. resp_valid at T+3.
- SW 0x200, wdata=0xCAFEF00D, dmem_stall=1 for 3 cycles → wen/addr=0x80/wdata stay stable for 4 cycles. resp_valid one cycle after stall falls. The next request is accepted that cycle.
- LH 0x101 and funct3=011 load → no ren/wen. resp_valid=1, resp_err=1, rdata=0 at T+1.

Source files
------------

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I data-memory access stage. It performs loads
//            (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a word-addressed
//            memory that has no byte enables. Sub-word stores are done as a
//            read-modify-write sequence. Load data is sign- or zero-extended.
// Ports    : clk, rst_n (async, active-low)
//            i_req_*  : request from EX (valid, we, funct3, byte addr, wdata)
//            o_req_ready : high only while IDLE
//            o_resp_* : one-cycle completion pulse, extended rdata, error flag
//            o_dmem_* / i_dmem_* : word address, read/write strobes, write
//                       word, read word, stall
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int DMEM_AW = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [2:0]         i_req_funct3,
  input  logic [31:0]        i_req_addr,
  input  logic [31:0]        i_req_wdata,
  output logic               o_resp_valid,
  output logic [31:0]        o_resp_rdata,
  output logic               o_resp_err,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic               o_dmem_ren,
  output logic               o_dmem_wen,
  output logic [31:0]        o_dmem_wdata,
  input  logic [31:0]        i_dmem_rdata,
  input  logic               i_dmem_stall
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_dmem_wdata;   // SW data, or req data until the RMW merge
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_bad;
  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  // Request legality is decoded from the live request inputs.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if (i_req_we) begin
      w_illegal = (i_req_funct3[2] == 1'b1) || (i_req_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                  (i_req_funct3 == 3'b111);
    end
    case (i_req_funct3[1:0])
      2'b01:   w_misalign = i_req_addr[0];
      2'b10:   w_misalign = (i_req_addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_bad = w_illegal || w_misalign;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Rejected requests never leave IDLE; they only raise an error pulse.
        if (w_accept && !w_bad) begin
          if (!i_req_we)                      w_state_nxt = S_RD;
          else if (i_req_funct3[1:0] == 2'b10) w_state_nxt = S_WR;
          else                                w_state_nxt = S_RMW_RD;
        end
      end
      S_RD:     if (!i_dmem_stall) w_state_nxt = S_IDLE;
      S_WR:     if (!i_dmem_stall) w_state_nxt = S_IDLE;
      S_RMW_RD: if (!i_dmem_stall) w_state_nxt = S_RMW_WR;
      S_RMW_WR: if (!i_dmem_stall) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  assign w_byte_sh = i_dmem_rdata >> {r_addr[1:0], 3'b000};
  assign w_half_sh = i_dmem_rdata >> {r_addr[1], 4'b0000};

  always_comb begin
    w_load = i_dmem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      3'b001:  w_load = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      3'b100:  w_load = {24'd0, w_byte_sh[7:0]};
      3'b101:  w_load = {16'd0, w_half_sh[15:0]};
      default: w_load = i_dmem_rdata;
    endcase
  end

  // During RMW_RD the write-data register still holds the raw store data,
  // so its low bits supply the byte/half being inserted.
  always_comb begin
    w_merge = i_dmem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_dmem_wdata[7:0];
    end else begin
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_dmem_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= 32'd0;
      r_funct3     <= 3'd0;
      r_dmem_wdata <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_addr       <= i_req_addr;
        r_funct3     <= i_req_funct3;
        r_dmem_wdata <= i_req_wdata;
        if (w_bad) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'd0;
        end
      end
      case (r_state)
        S_RD: begin
          if (!i_dmem_stall) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load;
          end
        end
        S_WR, S_RMW_WR: begin
          if (!i_dmem_stall) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
          end
        end
        S_RMW_RD: begin
          if (!i_dmem_stall) begin
            r_dmem_wdata <= w_merge;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_dmem_ren   = (r_state == S_RD) || (r_state == S_RMW_RD);
  assign o_dmem_wen   = (r_state == S_WR) || (r_state == S_RMW_WR);
  assign o_dmem_addr  = r_addr[DMEM_AW+1:2];
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_stall;

  int vectors     = 0;
  int miscompares = 0;

  load_store_unit #(.DMEM_AW(30)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_ren   (dmem_ren),
    .o_dmem_wen   (dmem_wen),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata),
    .i_dmem_stall (dmem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, check it is offered while ready, let the edge accept
  // it, then scramble the request inputs to prove they were captured.
  task automatic req(input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] word,
                         input logic [31:0] exp);
    req(1'b0, f3, addr, 32'd0);
    chk({tag, "_ren"}, {31'd0, dmem_ren}, 32'd1);
    dmem_rdata = word;
    tick();
    dmem_rdata = 32'd0;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"},   {31'd0, resp_err}, 32'd0);
  endtask

  task automatic do_rmw(input string tag, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input logic [31:0] exp_w);
    req(1'b1, f3, addr, wd);
    chk({tag, "_ren"},  {31'd0, dmem_ren}, 32'd1);
    chk({tag, "_wen0"}, {31'd0, dmem_wen}, 32'd0);
    chk({tag, "_addr"}, {2'b00, dmem_addr}, {2'b00, addr[31:2]});
    dmem_rdata = word;
    tick();
    dmem_rdata = 32'h0BAD_0BAD;
    chk({tag, "_wen"},    {31'd0, dmem_wen}, 32'd1);
    chk({tag, "_ren1"},   {31'd0, dmem_ren}, 32'd0);
    chk({tag, "_wdata"},  dmem_wdata, exp_w);
    chk({tag, "_valid0"}, {31'd0, resp_valid}, 32'd0);
    tick();
    dmem_rdata = 32'd0;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_err"},   {31'd0, resp_err}, 32'd0);
    chk({tag, "_wen2"},  {31'd0, dmem_wen}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr);
    req(we, f3, addr, 32'h1234_5678);
    chk({tag, "_ren"},   {31'd0, dmem_ren}, 32'd0);
    chk({tag, "_wen"},   {31'd0, dmem_wen}, 32'd0);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_err"},   {31'd0, resp_err}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    dmem_rdata = 32'd0;
    dmem_stall = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_valid",  {31'd0, resp_valid}, 32'd0);
    chk("rst_err",    {31'd0, resp_err}, 32'd0);
    chk("rst_rdata",  resp_rdata, 32'd0);
    chk("rst_ren",    {31'd0, dmem_ren}, 32'd0);
    chk("rst_wen",    {31'd0, dmem_wen}, 32'd0);
    chk("rst_addr",   {2'b00, dmem_addr}, 32'd0);
    chk("rst_wdata",  dmem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a stalled load
    dmem_stall = 1'b1;
    req(1'b0, 3'b010, 32'h0000_0104, 32'd0);
    chk("mid_ren_a", {31'd0, dmem_ren}, 32'd1);
    tick();
    chk("mid_ren_b", {31'd0, dmem_ren}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ren",   {31'd0, dmem_ren}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_addr",  {2'b00, dmem_addr}, 32'd0);
    dmem_stall = 1'b0;
    rst_n      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_spurious_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid_no_ren", {31'd0, dmem_ren}, 32'd0);
    end

    // LW 0x104, no stall
    req(1'b0, 3'b010, 32'h0000_0104, 32'd0);
    chk("lw_ren",    {31'd0, dmem_ren}, 32'd1);
    chk("lw_wen",    {31'd0, dmem_wen}, 32'd0);
    chk("lw_addr",   {2'b00, dmem_addr}, 32'h41);
    chk("lw_ready",  {31'd0, req_ready}, 32'd0);
    chk("lw_valid0", {31'd0, resp_valid}, 32'd0);
    dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rdata = 32'd0;
    chk("lw_valid", {31'd0, resp_valid}, 32'd1);
    chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("lw_err",   {31'd0, resp_err}, 32'd0);
    chk("lw_ren1",  {31'd0, dmem_ren}, 32'd0);
    chk("lw_ready1", {31'd0, req_ready}, 32'd1);
    tick();
    chk("lw_pulse",     {31'd0, resp_valid}, 32'd0);
    chk("lw_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

    // Sub-word loads with sign/zero extension
    do_load("lb_103",  3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu_103", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh_102",  3'b001, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lhu_102", 3'b101, 32'h0000_0102, 32'h80FF_0000, 32'h0000_80FF);
    do_load("lb_102",  3'b000, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_FFFF);
    do_load("lb_100",  3'b000, 32'h0000_0100, 32'h1234_5678, 32'h0000_0078);
    do_load("lh_100",  3'b001, 32'h0000_0100, 32'h1234_F678, 32'hFFFF_F678);

    // Read-modify-write stores
    do_rmw("sb_102", 3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344);
    do_rmw("sb_101", 3'b000, 32'h0000_0101, 32'hFFFF_FFCD, 32'h1122_3344, 32'h1122_CD44);
    do_rmw("sh_102", 3'b001, 32'h0000_0102, 32'h0000_5566, 32'h1122_3344, 32'h5566_3344);
    do_rmw("sh_100", 3'b001, 32'h0000_0100, 32'hAAAA_5566, 32'h1122_3344, 32'h1122_5566);

    // SW with 3 stall cycles, then a back-to-back load
    dmem_stall = 1'b1;
    req(1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_stall = 1'b0;
      chk("sw_wen",   {31'd0, dmem_wen}, 32'd1);
      chk("sw_ren",   {31'd0, dmem_ren}, 32'd0);
      chk("sw_addr",  {2'b00, dmem_addr}, 32'h80);
      chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
      chk("sw_valid0", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    chk("sw_valid", {31'd0, resp_valid}, 32'd1);
    chk("sw_err",   {31'd0, resp_err}, 32'd0);
    chk("sw_rdata", resp_rdata, 32'd0);
    chk("sw_wen1",  {31'd0, dmem_wen}, 32'd0);
    do_load("b2b_lw", 3'b010, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678);

    // Error responses
    do_err("lh_101",   1'b0, 3'b001, 32'h0000_0101);
    do_err("ld_f3_011", 1'b0, 3'b011, 32'h0000_0100);
    do_err("lw_102",   1'b0, 3'b010, 32'h0000_0102);
    do_err("st_f3_100", 1'b1, 3'b100, 32'h0000_0100);
    do_err("sh_103",   1'b1, 3'b001, 32'h0000_0103);
    tick();
    chk("err_pulse",      {31'd0, resp_valid}, 32'd0);
    chk("err_hold",       {31'd0, resp_err}, 32'd1);

    // A good access after an error clears the error flag
    do_load("lbu_after_err", 3'b100, 32'h0000_0101, 32'h0000_9900, 32'h0000_0099);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
